// File: rtl/rot_sink_pkg.sv
// Shared types and helpers for the rotated-video stream sink.
package rot_sink_pkg;

    // Capture state of the incoming raster.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACT = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_DROP     = 2'd3
    } sink_state_e;

    // Each FIFO entry carries two marker bits (sof, eol) on top of the pixel.
    localparam int ENTRY_CTRL_W = 2;

    function automatic int entry_width(input int depth);
        return depth + ENTRY_CTRL_W;
    endfunction

endpackage

// File: rtl/rot_sink_fifo.sv
// Synchronous FIFO with a registered output stage.
// Pointers carry one extra wrap bit so full and empty are told apart.
module rot_sink_fifo #(
    parameter int W  = 10,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    output logic         full_o,
    output logic         empty_o,
    input  logic         out_ready_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o
);

    localparam int N = 1 << AW;

    logic [W-1:0] mem_q [N];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         out_valid_q;
    logic [W-1:0] out_data_q;
    logic         push_ok;
    logic         pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    // A push into a full FIFO is refused even if a pop happens in the same cycle.
    assign push_ok = push_i & ~full_o;
    assign pop     = ~empty_o & (~out_valid_q | out_ready_i);

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

    // Storage array; no reset needed since pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    // Write and read pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Output register: holds while stalled, reloads when empty or accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mem_q[rd_ptr_q[AW-1:0]];
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/rotate_stream_sink.sv
// Receiving end of the rotated-video stream: samples the ce-qualified raster,
// tags pixels with sof/eol and forwards them through a FIFO to a valid/ready port.
// Optional geometry checking is built when ROT_SINK_GEOMCHK_EN is defined;
// otherwise geom_err is tied low.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, waiting for the first vblank rising edge
// WAIT_ACT | frame start pending; next accepted pixel carries sof
// ACTIVE   | capturing pixels of the current frame
// DROP     | FIFO overflowed; rest of frame discarded until next vblank
module rotate_stream_sink
    import rot_sink_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 240,
    parameter int HEIGHT  = 336,
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [DEPTH-1:0] video_in,
    input  logic             hblank,
    input  logic             vblank,
    output logic [DEPTH-1:0] pix_data,
    output logic             pix_sof,
    output logic             pix_eol,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             overflow,
    output logic             geom_err
);

    localparam int ENTRY_W = entry_width(DEPTH);

    typedef struct packed {
        logic             sof;
        logic             eol;
        logic [DEPTH-1:0] data;
    } entry_t;

    sink_state_e      state_q;
    logic             hblank_q;
    logic             vblank_q;
    logic             hold_vld_q;
    logic             hold_sof_q;
    logic [DEPTH-1:0] hold_data_q;
    logic             overflow_q;

    logic             acc;
    logic             hb_edge;
    logic             vb_edge;
    logic             line_end;
    logic             push;
    logic             drop;
    entry_t           push_entry;
    entry_t           out_entry;
    logic             fifo_full;
    logic             fifo_empty_unused;

    assign acc = ce & ~hblank & ~vblank &
                 ((state_q == ST_ACTIVE) | (state_q == ST_WAIT_ACT));

    assign hb_edge  = hblank & ~hblank_q;
    assign vb_edge  = vblank & ~vblank_q;
    assign line_end = hb_edge | vb_edge;

    // acc needs both blanks low and an edge needs one high, so they never
    // coincide; simultaneous h/v edges still produce a single push.
    assign push            = hold_vld_q & (acc | line_end);
    assign push_entry.sof  = hold_sof_q;
    assign push_entry.eol  = line_end;
    assign push_entry.data = hold_data_q;
    assign drop            = push & fifo_full;

    // Capture FSM, one-pixel hold register, blank edge history and overflow flag.
    // Blank history resets high so a blank already asserted at reset release
    // is not mistaken for a rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hblank_q    <= 1'b1;
            vblank_q    <= 1'b1;
            hold_vld_q  <= 1'b0;
            hold_sof_q  <= 1'b0;
            hold_data_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            hblank_q <= hblank;
            vblank_q <= vblank;
            if (drop) begin
                overflow_q <= 1'b1;
                state_q    <= ST_DROP;
                hold_vld_q <= 1'b0;
                hold_sof_q <= 1'b0;
            end else begin
                if (acc) begin
                    hold_vld_q  <= 1'b1;
                    hold_sof_q  <= (state_q == ST_WAIT_ACT);
                    hold_data_q <= video_in;
                end else if (line_end) begin
                    hold_vld_q <= 1'b0;
                end
                case (state_q)
                    ST_IDLE:     if (vb_edge) state_q <= ST_WAIT_ACT;
                    ST_WAIT_ACT: if (acc)     state_q <= ST_ACTIVE;
                    ST_ACTIVE:   if (vb_edge) state_q <= ST_WAIT_ACT;
                    ST_DROP:     if (vb_edge) state_q <= ST_WAIT_ACT;
                    default:                  state_q <= ST_IDLE;
                endcase
            end
        end
    end

    rot_sink_fifo #(
        .W  (ENTRY_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty_unused),
        .out_ready_i (pix_ready),
        .out_valid_o (pix_valid),
        .out_data_o  (out_entry)
    );

    assign pix_data = out_entry.data;
    assign pix_sof  = out_entry.sof;
    assign pix_eol  = out_entry.eol;
    assign overflow = overflow_q;

`ifdef ROT_SINK_GEOMCHK_EN
    localparam int PIX_CW  = $clog2(WIDTH + 1);
    localparam int LINE_CW = $clog2(HEIGHT + 1);
    localparam logic [PIX_CW-1:0]  WIDTH_C  = PIX_CW'(WIDTH);
    localparam logic [LINE_CW-1:0] HEIGHT_C = LINE_CW'(HEIGHT);

    logic [PIX_CW-1:0]  pix_cnt_q;
    logic [LINE_CW-1:0] line_cnt_q;
    logic [LINE_CW-1:0] line_cnt_d;
    logic               armed_q;
    logic               geom_err_q;
    logic               eol_push;

    assign eol_push = push & line_end & ~fifo_full;

    // Line count including a line closed in this very cycle (saturating).
    always_comb begin
        line_cnt_d = line_cnt_q;
        if (eol_push && (line_cnt_q != '1)) begin
            line_cnt_d = line_cnt_q + 1'b1;
        end
    end

    // Geometry counters; armed only after one complete frame so the partial
    // frame seen right after reset is never judged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            armed_q    <= 1'b0;
            geom_err_q <= 1'b0;
        end else begin
            if (vb_edge) begin
                pix_cnt_q  <= '0;
                line_cnt_q <= '0;
                if ((state_q == ST_ACTIVE) && !drop) begin
                    armed_q <= 1'b1;
                    if (armed_q && (line_cnt_d != HEIGHT_C)) begin
                        geom_err_q <= 1'b1;
                    end
                end
            end else begin
                line_cnt_q <= line_cnt_d;
                if (hb_edge) begin
                    pix_cnt_q <= '0;
                end else if (acc && (pix_cnt_q != '1)) begin
                    pix_cnt_q <= pix_cnt_q + 1'b1;
                end
            end
            if (hb_edge && hold_vld_q && armed_q && !drop && (pix_cnt_q != WIDTH_C)) begin
                geom_err_q <= 1'b1;
            end
        end
    end

    assign geom_err = geom_err_q;
`else
    logic unused_geom_params;
    assign unused_geom_params = (WIDTH != HEIGHT);
    assign geom_err = 1'b0;
`endif

endmodule

// File: tb/tb_rotate_stream_sink.sv
// Directed testbench for rotate_stream_sink. Expected beats are queued by the
// stimulus tasks as each pixel is driven and compared in order as they leave.
module tb_rotate_stream_sink;

    localparam int DEPTH   = 8;
    localparam int WIDTH   = 240;
    localparam int HEIGHT  = 3;
    localparam int FIFO_AW = 4;
    localparam int KEEP_ON_OVF = (1 << FIFO_AW) + 1;

`ifdef ROT_SINK_GEOMCHK_EN
    localparam logic GEOM_ON = 1'b1;
`else
    localparam logic GEOM_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             ce;
    logic [DEPTH-1:0] video_in;
    logic             hblank;
    logic             vblank;
    logic [DEPTH-1:0] pix_data;
    logic             pix_sof;
    logic             pix_eol;
    logic             pix_valid;
    logic             pix_ready = 1'b0;
    logic             overflow;
    logic             geom_err;

    int checks = 0;
    int errors = 0;

    rotate_stream_sink #(
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .video_in  (video_in),
        .hblank    (hblank),
        .vblank    (vblank),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .overflow  (overflow),
        .geom_err  (geom_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Ready pattern: 0 = always, 1 = one cycle in three, 2 = never.
    int ready_mode = 0;
    int rcyc = 0;
    always @(posedge clk) begin
        #2;
        rcyc++;
        case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ((rcyc % 3) == 0);
            default: pix_ready = 1'b0;
        endcase
    end

    // Output monitor: in-order compare, and stability while stalled.
    logic [9:0] exp_q [$];
    int         beat_cnt = 0;
    int         eol_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_beat = '0;
    logic [9:0] cur_beat;
    always @(negedge clk) begin
        cur_beat = {pix_sof, pix_eol, pix_data};
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(pix_valid), 32'd1);
                check("stall_hold", 32'(cur_beat), 32'(prev_beat));
            end
            if (pix_valid && pix_ready) begin
                beat_cnt++;
                if (pix_eol) eol_cnt++;
                check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("beat", 32'(cur_beat), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = pix_valid && !pix_ready;
            prev_beat  = cur_beat;
        end
    end

    logic first_pix = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vblank_pulse();
        ce = 1'b0;
        hblank = 1'b1;
        vblank = 1'b1;
        repeat (4) tick();
        hblank = 1'b0;
        vblank = 1'b0;
        repeat (2) tick();
        first_pix = 1'b1;
    endtask

    // One line of n pixels, ce every 'period' cycles; only the first 'keep'
    // pixels are expected at the output. end_both closes the line with
    // hblank and vblank rising together (which also starts the next frame).
    task automatic send_line(input int n, input int period, input int base,
                             input int keep, input int gap, input int ready_rel,
                             input logic end_both);
        for (int i = 0; i < n; i++) begin
            if (i == ready_rel) ready_mode = 0;
            ce = 1'b1;
            video_in = DEPTH'(base + i);
            if (i < keep) exp_q.push_back({first_pix, (i == n - 1), video_in});
            first_pix = 1'b0;
            tick();
            for (int k = 1; k < period; k++) begin
                ce = 1'b0;
                tick();
            end
        end
        ce = 1'b0;
        if (end_both) begin
            hblank = 1'b1;
            vblank = 1'b1;
            repeat (4) tick();
            hblank = 1'b0;
            vblank = 1'b0;
            repeat (2) tick();
            first_pix = 1'b1;
        end else begin
            hblank = 1'b1;
            repeat (gap) tick();
            hblank = 1'b0;
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    int b0;
    int e0;

    initial begin
        reset = 1'b1;
        ce = 1'b0;
        hblank = 1'b0;
        vblank = 1'b0;
        video_in = '0;
        repeat (3) tick();

        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_data",  32'(pix_data),  32'd0);
        check("rst_sof",   32'(pix_sof),   32'd0);
        check("rst_eol",   32'(pix_eol),   32'd0);
        check("rst_ovf",   32'(overflow),  32'd0);
        check("rst_geom",  32'(geom_err),  32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Frame 1: 3 x 240, ce every cycle, ready always high.
        b0 = beat_cnt;
        vblank_pulse();
        for (int l = 0; l < 3; l++) send_line(240, 1, l * 16, 1000, 4, -1, 1'b0);
        vblank_pulse();
        wait_drain("f1_drain");
        check("f1_beats", 32'(beat_cnt - b0), 32'd720);
        check("f1_ovf", 32'(overflow), 32'd0);

        // Frame 2: correct geometry, last line closed by hblank+vblank together.
        b0 = beat_cnt;
        e0 = eol_cnt;
        send_line(240, 1, 7, 1000, 4, -1, 1'b0);
        send_line(240, 1, 99, 1000, 4, -1, 1'b0);
        send_line(240, 1, 200, 1000, 4, -1, 1'b1);
        wait_drain("f2_drain");
        check("f2_beats", 32'(beat_cnt - b0), 32'd720);
        check("f2_eols", 32'(eol_cnt - e0), 32'd3);
        check("f2_geom", 32'(geom_err), 32'd0);

        // Frame 3: middle line one pixel short.
        b0 = beat_cnt;
        send_line(240, 1, 3, 1000, 4, -1, 1'b0);
        send_line(239, 1, 50, 1000, 4, -1, 1'b0);
        send_line(240, 1, 77, 1000, 4, -1, 1'b0);
        vblank_pulse();
        wait_drain("f3_drain");
        check("f3_beats", 32'(beat_cnt - b0), 32'd719);
        check("f3_geom", 32'(geom_err), 32'(GEOM_ON));

        // Frame 4: ce every 2nd cycle, ready one cycle in three.
        b0 = beat_cnt;
        ready_mode = 1;
        for (int l = 0; l < 3; l++) send_line(8, 2, 128 + l * 8, 1000, 30, -1, 1'b0);
        vblank_pulse();
        wait_drain("f4_drain");
        check("f4_beats", 32'(beat_cnt - b0), 32'd24);
        check("f4_ovf", 32'(overflow), 32'd0);
        ready_mode = 0;
        repeat (3) tick();

        // Frame 5: ready low for 40 cycles -> overflow after 17 pixels, rest dropped.
        b0 = beat_cnt;
        ready_mode = 2;
        send_line(240, 1, 0, KEEP_ON_OVF, 4, 40, 1'b0);
        check("f5_ovf", 32'(overflow), 32'd1);
        send_line(10, 1, 60, 0, 4, -1, 1'b0);
        vblank_pulse();
        // Frame 6: delivered intact after the drop.
        for (int l = 0; l < 3; l++) send_line(240, 1, 33 + l, 1000, 4, -1, 1'b0);
        vblank_pulse();
        wait_drain("f6_drain");
        check("f56_beats", 32'(beat_cnt - b0), 32'(KEEP_ON_OVF + 720));
        check("f6_ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-line with beats queued behind a stalled output.
        ready_mode = 2;
        for (int i = 0; i < 7; i++) begin
            ce = 1'b1;
            video_in = DEPTH'(i + 90);
            tick();
        end
        ce = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mrst_valid", 32'(pix_valid), 32'd0);
        check("mrst_data",  32'(pix_data),  32'd0);
        check("mrst_sof",   32'(pix_sof),   32'd0);
        check("mrst_eol",   32'(pix_eol),   32'd0);
        check("mrst_ovf",   32'(overflow),  32'd0);
        check("mrst_geom",  32'(geom_err),  32'd0);
        tick();
        reset = 1'b0;
        ready_mode = 0;
        b0 = beat_cnt;
        for (int i = 0; i < 10; i++) begin
            ce = 1'b1;
            video_in = DEPTH'(i + 170);
            tick();
        end
        ce = 1'b0;
        hblank = 1'b1;
        repeat (4) tick();
        hblank = 1'b0;
        repeat (20) tick();
        check("mrst_idle_beats", 32'(beat_cnt - b0), 32'd0);

        b0 = beat_cnt;
        vblank_pulse();
        for (int l = 0; l < 3; l++) send_line(240, 1, 11 * l + 5, 1000, 4, -1, 1'b0);
        vblank_pulse();
        wait_drain("f7_drain");
        check("f7_beats", 32'(beat_cnt - b0), 32'd720);
        check("f7_ovf", 32'(overflow), 32'd0);
        check("f7_geom", 32'(geom_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
